// File: rtl/quad_decoder_index.sv
// quad_decoder_index: x4 quadrature decoder with illegal-transition counting and index capture
module quad_decoder_index #(
  parameter int size = 16,
  parameter int err_size = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          q,
  input  logic                index,
  input  logic                err_clr,
  output logic [size-1:0]     count,
  output logic [size-1:0]     sample,
  output logic [size-1:0]     delta,
  output logic                sample_valid,
  output logic                delta_valid,
  output logic                dir,
  output logic [err_size-1:0] err_count
);
  logic armed, index_seen, index_prev;
  logic [1:0] q_prev, d;
  logic up, dn, ill, fall;
  logic [size-1:0] count_next;
  // Gray phase to ordinal: 00->0, 01->1, 11->2, 10->3; the ordinal difference classifies the step
  always_comb begin
    d = {q[1], q[1] ^ q[0]} - {q_prev[1], q_prev[1] ^ q_prev[0]};
    up = armed && d == 2'd1;
    dn = armed && d == 2'd3;
    ill = armed && d == 2'd2;
    fall = armed && index_prev && !index;
    count_next = up ? count + 1'b1 : dn ? count - 1'b1 : count;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
      index_seen <= 1'b0;
      index_prev <= 1'b0;
      q_prev <= 2'b00;
      count <= '0;
      sample <= '0;
      delta <= '0;
      sample_valid <= 1'b0;
      delta_valid <= 1'b0;
      dir <= 1'b0;
      err_count <= '0;
    end else begin
      armed <= 1'b1;
      q_prev <= q;
      index_prev <= index;
      count <= count_next;
      if (up || dn) dir <= up;
      err_count <= err_clr ? (ill ? err_size'(1) : '0) :
                   (ill && err_count != '1) ? err_count + 1'b1 : err_count;
      sample_valid <= fall;
      delta_valid <= fall && index_seen;
      if (fall) begin
        sample <= count_next;
        index_seen <= 1'b1;
        if (index_seen) delta <= count_next - sample;
      end
    end
  end
endmodule

// File: tb/tb_quad_decoder_index.sv
// tb_quad_decoder_index: directed and random checks against a phase-arithmetic reference model
module tb_quad_decoder_index;
  logic clk = 0, rst = 1, index = 1, err_clr = 0;
  logic [1:0] q = 2'b00;
  logic [15:0] count, sample, delta;
  logic sample_valid, delta_valid, dir;
  logic [7:0] err_count;
  int tests = 0, fails = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ph_i = 0;
  logic cur_idx = 1;
  bit m_armed, m_ip, m_seen, m_dir, m_sv, m_dv;
  logic [1:0] m_qp;
  int m_count, m_err, m_sample, m_delta;

  quad_decoder_index #(.size(16), .err_size(8)) dut (
    .clk(clk), .rst(rst), .q(q), .index(index), .err_clr(err_clr),
    .count(count), .sample(sample), .delta(delta), .sample_valid(sample_valid),
    .delta_valid(delta_valid), .dir(dir), .err_count(err_count));

  always #5 clk = ~clk;

  function automatic int ph(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_armed = 0; m_ip = 0; m_seen = 0; m_dir = 0; m_sv = 0; m_dv = 0; m_qp = 0;
    m_count = 0; m_err = 0; m_sample = 0; m_delta = 0;
  endtask

  task automatic m_step();
    int dd;
    bit ill;
    if (!m_armed) begin
      m_armed = 1; m_qp = q; m_ip = index; m_sv = 0; m_dv = 0;
      return;
    end
    dd = (ph(q) - ph(m_qp) + 4) % 4;
    ill = (dd == 2);
    if (dd == 1) begin m_count = (m_count + 1) % 65536; m_dir = 1; end
    else if (dd == 3) begin m_count = (m_count + 65535) % 65536; m_dir = 0; end
    if (err_clr) m_err = ill ? 1 : 0;
    else if (ill && m_err < 255) m_err++;
    m_sv = 0; m_dv = 0;
    if (m_ip && !index) begin
      m_sv = 1;
      if (m_seen) begin m_delta = (m_count - m_sample + 65536) % 65536; m_dv = 1; end
      m_sample = m_count;
      m_seen = 1;
    end
    m_qp = q; m_ip = index;
  endtask

  task automatic check_all();
    chk("count", count, m_count);
    chk("sample", sample, m_sample);
    chk("delta", delta, m_delta);
    chk("sample_valid", sample_valid, m_sv);
    chk("delta_valid", delta_valid, m_dv);
    chk("dir", dir, m_dir);
    chk("err_count", err_count, m_err);
  endtask

  task automatic cyc(input logic [1:0] nq, input logic ni, input logic nc);
    @(negedge clk);
    q = nq; index = ni; err_clr = nc;
    @(posedge clk);
    m_step();
    #1 check_all();
  endtask

  task automatic do_reset(input logic [1:0] nq);
    @(negedge clk);
    rst = 1; q = nq; index = 1; err_clr = 0;
    m_reset();
    #1 check_all();
    @(negedge clk);
    rst = 0;
    ph_i = ph(nq); cur_idx = 1;
  endtask

  task automatic steps(input int n, input int up_dir, input int hold);
    for (int i = 0; i < n; i++) begin
      ph_i = (ph_i + (up_dir ? 1 : 3)) % 4;
      for (int k = 0; k < hold; k++) cyc(seq[ph_i], cur_idx, 0);
    end
  endtask

  initial begin
    m_reset();
    do_reset(2'b00);
    for (int i = 0; i < 5; i++) cyc(2'b00, 1, 0);
    chk("idle_count", count, 0);
    // arming edge with q != 00 must not count
    do_reset(2'b01);
    cyc(2'b01, 1, 0);
    chk("arm_count", count, 0);
    cyc(2'b01, 1, 0);
    do_reset(2'b00);
    cyc(2'b00, 1, 0);
    steps(8, 1, 2);
    chk("up8", count, 8);
    chk("up8_dir", dir, 1);
    steps(3, 0, 2);
    chk("down3", count, 5);
    chk("down3_dir", dir, 0);
    do_reset(2'b00);
    cyc(2'b00, 1, 0);
    steps(1, 0, 1);
    chk("wrap_down", count, 16'hFFFF);
    steps(1, 1, 1);
    chk("wrap_up", count, 0);
    cyc(2'b11, 1, 0);
    chk("jump_count", count, 0);
    chk("jump_err", err_count, 1);
    for (int i = 0; i < 300; i++) cyc(i[0] ? 2'b11 : 2'b00, 1, 0);
    chk("err_sat", err_count, 255);
    cyc(2'b00, 1, 1);
    chk("clr_jump", err_count, 1);
    cyc(2'b00, 1, 1);
    chk("clr_only", err_count, 0);
    ph_i = 0;
    // index capture and delta
    do_reset(2'b00);
    cyc(2'b00, 1, 0);
    steps(100, 1, 1);
    cyc(seq[ph_i], 0, 0);
    chk("samp100", sample, 100);
    cur_idx = 1;
    cyc(seq[ph_i], 1, 0);
    steps(400, 1, 1);
    cyc(seq[ph_i], 0, 0);
    chk("samp500", sample, 500);
    chk("delta400", delta, 400);
    cur_idx = 0;
    for (int i = 0; i < 10; i++) cyc(seq[ph_i], 0, 0);
    chk("held_sv", sample_valid, 0);
    // step coincident with index fall
    do_reset(2'b00);
    cyc(2'b00, 1, 0);
    steps(41, 1, 1);
    ph_i = (ph_i + 1) % 4;
    cyc(seq[ph_i], 0, 0);
    chk("coin_count", count, 42);
    chk("coin_sample", sample, 42);
    cyc(seq[ph_i], 1, 0);
    steps(5, 1, 1);
    @(negedge clk);
    #2 rst = 1;
    m_reset();
    #1 check_all();
    chk("async_count", count, 0);
    @(negedge clk);
    rst = 0; q = seq[ph_i]; index = 1;
    cyc(seq[ph_i], 1, 0);
    cyc(seq[ph_i], 0, 0);
    chk("post_rst_dv", delta_valid, 0);
    chk("post_rst_sv", sample_valid, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(2'($urandom_range(0, 3)), $urandom_range(0, 5) != 0, $urandom_range(0, 15) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
